// File: rtl/timer_pkg.sv
// Register map and field positions shared by the multi-channel APB timer.
package timer_pkg;

  localparam logic [1:0] OFF_TDR  = 2'd0;
  localparam logic [1:0] OFF_TCR  = 2'd1;
  localparam logic [1:0] OFF_TSR  = 2'd2;
  localparam logic [1:0] OFF_TCNT = 2'd3;

  localparam int CH_STRIDE = 4;
  localparam int CKS_W     = 3;
  // Largest divider is 2^(2^CKS_W), so the prescaler needs 2^CKS_W bits.
  localparam int PSC_W     = 1 << CKS_W;

  localparam int TCR_CKS  = 0;
  localparam int TCR_OS   = 3;
  localparam int TCR_EN   = 4;
  localparam int TCR_DOWN = 5;
  localparam int TCR_LOAD = 6;
  localparam int TCR_IE   = 7;

  localparam int TSR_OVF = 0;
  localparam int TSR_UDF = 1;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: prescaler, up/down auto-reload counter, TDR/TCR/TSR and irq.
// One-shot mode (TCR.OS) exists only when TMR_ONESHOT_EN is defined.
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_tdr,
  input  logic              wr_tcr,
  input  logic              wr_tsr,
  input  logic [DATA_W-1:0] wdata,
  output logic [CNT_W-1:0]  tdr,
  output logic [7:0]        tcr,
  output logic [1:0]        tsr,
  output logic [CNT_W-1:0]  cnt,
  output logic              irq
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] tdr_q, tdr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic [CKS_W-1:0] cks_q, cks_d;
  logic             os_q, os_d;
  logic             en_q, en_d;
  logic             down_q, down_d;
  logic             ie_q, ie_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             irq_q, irq_d;

  logic [PSC_W-1:0] psc_mask;
  logic             tick;
  logic             load;
  logic             cks_chg;
  logic             ovf_set;
  logic             udf_set;

  always_comb begin
    // Low CKS+1 bits set: a tick fires once every 2^(CKS+1) enabled cycles.
    psc_mask = ~({{(PSC_W-1){1'b1}}, 1'b0} << cks_q);
    tick     = en_q & ((psc_q & psc_mask) == psc_mask);
    load     = wr_tcr & wdata[TCR_LOAD];
    cks_chg  = wr_tcr & (wdata[TCR_CKS +: CKS_W] != cks_q);

    ovf_set = 1'b0;
    udf_set = 1'b0;
    cnt_d   = cnt_q;
    // LOAD beats a tick; reloads always use the TDR value from before this edge.
    if (load) begin
      cnt_d = tdr_q;
    end else if (tick) begin
      if (!down_q) begin
        if (cnt_q == CNT_MAX) begin
          cnt_d   = tdr_q;
          ovf_set = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        if (cnt_q == '0) begin
          cnt_d   = tdr_q;
          udf_set = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end

    ovf_d = (ovf_q & ~(wr_tsr & wdata[TSR_OVF])) | ovf_set;
    udf_d = (udf_q & ~(wr_tsr & wdata[TSR_UDF])) | udf_set;
    tdr_d = wr_tdr ? wdata[CNT_W-1:0] : tdr_q;

    cks_d  = cks_q;
    en_d   = en_q;
    down_d = down_q;
    ie_d   = ie_q;
`ifdef TMR_ONESHOT_EN
    os_d = os_q;
    if (os_q & (ovf_set | udf_set)) begin
      en_d = 1'b0;
    end
    if (wr_tcr) begin
      os_d = wdata[TCR_OS];
    end
`else
    os_d = 1'b0;
`endif
    if (wr_tcr) begin
      cks_d  = wdata[TCR_CKS +: CKS_W];
      en_d   = wdata[TCR_EN];
      down_d = wdata[TCR_DOWN];
      ie_d   = wdata[TCR_IE];
    end

    if (load | cks_chg | (en_d & ~en_q)) begin
      psc_d = '0;
    end else if (en_q) begin
      psc_d = psc_q + 1'b1;
    end else begin
      psc_d = psc_q;
    end

    irq_d = ie_q & (ovf_q | udf_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdr_q  <= '0;
      cnt_q  <= '0;
      psc_q  <= '0;
      cks_q  <= '0;
      os_q   <= 1'b0;
      en_q   <= 1'b0;
      down_q <= 1'b0;
      ie_q   <= 1'b0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      tdr_q  <= tdr_d;
      cnt_q  <= cnt_d;
      psc_q  <= psc_d;
      cks_q  <= cks_d;
      os_q   <= os_d;
      en_q   <= en_d;
      down_q <= down_d;
      ie_q   <= ie_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
      irq_q  <= irq_d;
    end
  end

  // LOAD is a strobe and always reads back as 0.
  assign tdr = tdr_q;
  assign tcr = {ie_q, 1'b0, down_q, en_q, os_q, cks_q};
  assign tsr = {udf_q, ovf_q};
  assign cnt = cnt_q;
  assign irq = irq_q;

endmodule

// File: rtl/apb_timer_mch.sv
// Multi-channel APB timer: address decode, read mux and error response around NUM_CH channels.
// Define TMR_ONESHOT_EN to enable the per-channel one-shot bit (TCR.OS).
module apb_timer_mch
  import timer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [NUM_CH-1:0] irq
);

  localparam int OFF_W = $clog2(CH_STRIDE);
  localparam int IDX_W = ADDR_W - OFF_W;

  logic [IDX_W-1:0] ch_idx;
  logic [OFF_W-1:0] off;
  logic             ch_ok;
  logic             access;
  logic             wr_ok;
  logic [DATA_W-1:0] rd_mux;

  logic [CNT_W-1:0] ch_tdr [NUM_CH];
  logic [7:0]       ch_tcr [NUM_CH];
  logic [1:0]       ch_tsr [NUM_CH];
  logic [CNT_W-1:0] ch_cnt [NUM_CH];

  assign ch_idx = paddr[ADDR_W-1:OFF_W];
  assign off    = paddr[OFF_W-1:0];
  assign ch_ok  = ch_idx < IDX_W'(NUM_CH);
  assign access = psel & penable;
  // Erroring writes (missing channel or read-only TCNT) never reach a channel.
  assign wr_ok  = access & pwrite & ch_ok & (off != OFF_TCNT);

  assign pready  = 1'b1;
  assign pslverr = access & (~ch_ok | (pwrite & (off == OFF_TCNT)));

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic ch_wr;
    assign ch_wr = wr_ok & (ch_idx == IDX_W'(g));

    timer_channel #(
      .CNT_W  (CNT_W),
      .DATA_W (DATA_W)
    ) u_channel (
      .clk    (pclk),
      .rst_n  (presetn),
      .wr_tdr (ch_wr & (off == OFF_TDR)),
      .wr_tcr (ch_wr & (off == OFF_TCR)),
      .wr_tsr (ch_wr & (off == OFF_TSR)),
      .wdata  (pwdata),
      .tdr    (ch_tdr[g]),
      .tcr    (ch_tcr[g]),
      .tsr    (ch_tsr[g]),
      .cnt    (ch_cnt[g]),
      .irq    (irq[g])
    );
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_idx == IDX_W'(i)) begin
        case (off)
          OFF_TDR: rd_mux = DATA_W'(ch_tdr[i]);
          OFF_TCR: rd_mux = DATA_W'(ch_tcr[i]);
          OFF_TSR: rd_mux = DATA_W'(ch_tsr[i]);
          default: rd_mux = DATA_W'(ch_cnt[i]);
        endcase
      end
    end
    prdata = (access & ~pwrite & ch_ok) ? rd_mux : '0;
  end

endmodule

// File: tb/tb_apb_timer_mch.sv
// Self-checking bench for apb_timer_mch: reset/decode table, directed timer sequences,
// randomized APB traffic against a cycle-level behavioural model of the timer rules.
module tb_apb_timer_mch;

  localparam int NUM_CH = 4;
`ifdef TMR_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif

  logic       pclk    = 1'b0;
  logic       presetn = 1'b0;
  logic       psel    = 1'b0;
  logic       penable = 1'b0;
  logic       pwrite  = 1'b0;
  logic [7:0] paddr   = 8'h00;
  logic [7:0] pwdata  = 8'h00;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;
  logic [3:0] irq;

  apb_timer_mch #(
    .NUM_CH (4),
    .CNT_W  (8),
    .DATA_W (8),
    .ADDR_W (8)
  ) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .irq     (irq)
  );

  // ---------------- clock / reset ----------------
  always #5 pclk = ~pclk;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [7:0] exp_q[$];

  // ---------------- behavioural model ----------------
  // State per channel, advanced once per pclk edge from the bus inputs the bench drives.
  int m_tdr   [NUM_CH];
  int m_cnt   [NUM_CH];
  int m_cks   [NUM_CH];
  int m_phase [NUM_CH];
  bit m_os    [NUM_CH];
  bit m_en    [NUM_CH];
  bit m_down  [NUM_CH];
  bit m_ie    [NUM_CH];
  bit m_ovf   [NUM_CH];
  bit m_udf   [NUM_CH];
  bit m_irq   [NUM_CH];

  function automatic void model_clear();
    for (int c = 0; c < NUM_CH; c++) begin
      m_tdr[c] = 0; m_cnt[c] = 0; m_cks[c] = 0; m_phase[c] = 0;
      m_os[c] = 0; m_en[c] = 0; m_down[c] = 0; m_ie[c] = 0;
      m_ovf[c] = 0; m_udf[c] = 0; m_irq[c] = 0;
    end
  endfunction

  function automatic void model_step();
    int off;
    int ch;
    bit wr;
    bit tick;
    bit load;
    bit old_en;
    bit ev;
    int old_tdr;
    int old_cks;
    bit new_irq;
    off = int'(paddr) % 4;
    ch  = int'(paddr) / 4;
    for (int c = 0; c < NUM_CH; c++) begin
      wr      = psel && penable && pwrite && (ch == c) && (off != 3);
      tick    = m_en[c] && (((m_phase[c] + 1) % (2 << m_cks[c])) == 0);
      load    = wr && (off == 1) && pwdata[6];
      old_en  = m_en[c];
      old_tdr = m_tdr[c];
      old_cks = m_cks[c];
      new_irq = m_ie[c] && (m_ovf[c] || m_udf[c]);
      ev      = 0;
      if (wr && off == 2) begin
        if (pwdata[0]) m_ovf[c] = 0;
        if (pwdata[1]) m_udf[c] = 0;
      end
      if (load) begin
        m_cnt[c] = old_tdr;
      end else if (tick && !m_down[c]) begin
        if (m_cnt[c] == 255) begin m_cnt[c] = old_tdr; m_ovf[c] = 1; ev = 1; end
        else m_cnt[c] = m_cnt[c] + 1;
      end else if (tick) begin
        if (m_cnt[c] == 0) begin m_cnt[c] = old_tdr; m_udf[c] = 1; ev = 1; end
        else m_cnt[c] = m_cnt[c] - 1;
      end
      if (ev && m_os[c]) m_en[c] = 0;
      if (wr && off == 0) m_tdr[c] = int'(pwdata);
      if (wr && off == 1) begin
        m_cks[c]  = int'(pwdata[2:0]);
        m_os[c]   = ONESHOT && pwdata[3];
        m_en[c]   = pwdata[4];
        m_down[c] = pwdata[5];
        m_ie[c]   = pwdata[7];
      end
      if (load || (m_en[c] && !old_en) || (m_cks[c] != old_cks)) m_phase[c] = 0;
      else if (old_en) m_phase[c] = (m_phase[c] + 1) % 256;
      m_irq[c] = new_irq;
    end
  endfunction

  always @(posedge pclk or negedge presetn) begin
    if (!presetn) model_clear();
    else model_step();
  end

  function automatic logic [7:0] model_rd(input logic [7:0] a);
    int c;
    c = int'(a) / 4;
    if (c >= NUM_CH) return 8'h00;
    case (a[1:0])
      2'd0: return 8'(m_tdr[c]);
      2'd1: return {m_ie[c], 1'b0, m_down[c], m_en[c], m_os[c], 3'(m_cks[c])};
      2'd2: return {6'b0, m_udf[c], m_ovf[c]};
      default: return 8'(m_cnt[c]);
    endcase
  endfunction

  function automatic logic model_err(input logic [7:0] a, input logic wr);
    return ((int'(a) / 4) >= NUM_CH) || (wr && a[1:0] == 2'd3);
  endfunction

  function automatic logic [3:0] model_irq();
    return {m_irq[3], m_irq[2], m_irq[1], m_irq[0]};
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One APB transfer; DUT outputs and model expectations are captured together mid access phase.
  task automatic apb_xfer(input logic wr, input logic [7:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output logic err, output logic rdy,
                          output logic [7:0] e_rd, output logic e_err, output logic [3:0] e_irq,
                          output logic [3:0] irq_s);
    @(negedge pclk);
    psel = 1'b1; pwrite = wr; paddr = a; pwdata = d; penable = 1'b0;
    @(negedge pclk);
    penable = 1'b1;
    #1;
    rd    = prdata;
    err   = pslverr;
    rdy   = pready;
    irq_s = irq;
    e_rd  = wr ? 8'h00 : model_rd(a);
    e_err = model_err(a, wr);
    e_irq = model_irq();
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [7:0] rd);
    logic err, rdy, e_err;
    logic [7:0] e_rd;
    logic [3:0] e_irq, irq_s;
    apb_xfer(1'b0, a, 8'h00, rd, err, rdy, e_rd, e_err, e_irq, irq_s);
    exp_q.push_back(e_rd);
    check($sformatf("rd[%02h]", a), rd, exp_q.pop_front());
    check($sformatf("rd_pslverr[%02h]", a), err, e_err);
    check("irq", irq_s, e_irq);
    check("pready", rdy, 1'b1);
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [7:0] d);
    logic err, rdy, e_err;
    logic [7:0] rd, e_rd;
    logic [3:0] e_irq, irq_s;
    apb_xfer(1'b1, a, d, rd, err, rdy, e_rd, e_err, e_irq, irq_s);
    check($sformatf("wr_pslverr[%02h]", a), err, e_err);
  endtask

  // ---------------- decode table ----------------
  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp_rd;
    logic       exp_err;
  } vec_t;

  vec_t tbl[22];

  task automatic run_table(input string tag);
    logic err, rdy, e_err;
    logic [7:0] rd, e_rd;
    logic [3:0] e_irq, irq_s;
    for (int i = 0; i < 22; i++) begin
      apb_xfer(tbl[i].wr, tbl[i].addr, tbl[i].data, rd, err, rdy, e_rd, e_err, e_irq, irq_s);
      if (!tbl[i].wr) check($sformatf("%s_rd[%02h]", tag, tbl[i].addr), rd, tbl[i].exp_rd);
      check($sformatf("%s_err[%02h]", tag, tbl[i].addr), err, tbl[i].exp_err);
      check($sformatf("%s_irq", tag), irq_s, 4'h0);
      check($sformatf("%s_pready", tag), rdy, 1'b1);
    end
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] rd;
  logic [7:0] a;
  logic [7:0] d;

  initial begin
    for (int i = 0; i < 16; i++) tbl[i] = '{1'b0, 8'(i), 8'h00, 8'h00, 1'b0};
    tbl[16] = '{1'b0, 8'h10, 8'h00, 8'h00, 1'b1};
    tbl[17] = '{1'b0, 8'h1F, 8'h00, 8'h00, 1'b1};
    tbl[18] = '{1'b0, 8'hFF, 8'h00, 8'h00, 1'b1};
    tbl[19] = '{1'b1, 8'h03, 8'h55, 8'h00, 1'b1};
    tbl[20] = '{1'b1, 8'h13, 8'hAA, 8'h00, 1'b1};
    tbl[21] = '{1'b0, 8'h03, 8'h00, 8'h00, 1'b0};

    repeat (3) @(negedge pclk);
    presetn = 1'b1;

    // Reset values and address decode.
    run_table("reset");

    // ch0 free-running /2, then /4 after LOAD, then /256.
    apb_write(8'h01, 8'h10);
    repeat (100) @(posedge pclk);
    apb_read(8'h03, rd);
    check("ch0_div2_cnt", rd, 8'h32);
    apb_write(8'h01, 8'h11);
    apb_write(8'h01, 8'h51);
    repeat (100) @(posedge pclk);
    apb_read(8'h03, rd);
    check("ch0_div4_cnt", rd, 8'h19);
    apb_read(8'h01, rd);
    check("ch0_tcr_load_rd0", rd, 8'h11);
    apb_write(8'h01, 8'h57);
    repeat (512) @(posedge pclk);
    apb_read(8'h03, rd);
    check("ch0_div256_cnt", rd, 8'h02);

    // ch1 overflow with reload, irq, W1C.
    apb_write(8'h04, 8'hF0);
    apb_write(8'h05, 8'hD0);
    repeat (32) @(posedge pclk);
    apb_read(8'h07, rd);
    check("ch1_reload_cnt", rd, 8'hF0);
    apb_read(8'h06, rd);
    check("ch1_ovf", rd, 8'h01);
    check("ch1_irq_set", irq[1], 1'b1);
    apb_write(8'h06, 8'h01);
    @(negedge pclk); #1;
    check("ch1_irq_clr", irq[1], 1'b0);
    apb_read(8'h06, rd);
    check("ch1_ovf_clr", rd, 8'h00);

    // ch2 underflow with reload; other channels unaffected.
    apb_write(8'h08, 8'h05);
    apb_write(8'h09, 8'h70);
    repeat (12) @(posedge pclk);
    apb_read(8'h0B, rd);
    check("ch2_reload_cnt", rd, 8'h05);
    apb_read(8'h0A, rd);
    check("ch2_udf", rd, 8'h02);
    apb_read(8'h03, rd);
    apb_read(8'h07, rd);
    apb_read(8'h0F, rd);
    check("ch3_idle_cnt", rd, 8'h00);

    // Error responses.
    apb_read(8'h10, rd);
    check("bad_ch_rd", rd, 8'h00);
    apb_write(8'h03, 8'hA5);
    apb_read(8'h03, rd);

`ifdef TMR_ONESHOT_EN
    apb_write(8'h0C, 8'hFE);
    apb_write(8'h0D, 8'h58);
    repeat (8) @(posedge pclk);
    apb_read(8'h0F, rd);
    check("ch3_os_cnt", rd, 8'hFE);
    apb_read(8'h0D, rd);
    check("ch3_os_tcr", rd, 8'h08);
    apb_read(8'h0E, rd);
    check("ch3_os_ovf", rd, 8'h01);
    repeat (10) @(posedge pclk);
    apb_read(8'h0F, rd);
    check("ch3_os_hold", rd, 8'hFE);
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      a = 8'($urandom_range(0, 19));
      if ($urandom_range(0, 1) == 1) begin
        d = 8'($urandom_range(0, 255));
        if (a[1:0] == 2'd1) d[2] = 1'b0;
        apb_write(a, d);
      end else begin
        apb_read(a, rd);
      end
      repeat ($urandom_range(0, 4)) @(posedge pclk);
    end

    // Asynchronous reset while counting.
    apb_write(8'h05, 8'hB0);
    apb_write(8'h09, 8'h30);
    repeat (7) @(posedge pclk);
    @(negedge pclk);
    #2;
    presetn = 1'b0;
    #1;
    check("async_rst_irq", irq, 4'h0);
    check("async_rst_prdata", prdata, 8'h00);
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    run_table("post_rst");
    repeat (20) @(posedge pclk);
    for (int c = 0; c < NUM_CH; c++) begin
      apb_read(8'(c * 4 + 3), rd);
      check($sformatf("post_rst_hold_ch%0d", c), rd, 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
